pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 3, SHALL be the EX-stage occupancy in cycles of a MUL/MULH/MULHSU/MULHU instruction, legal range 2..63.
REQ-002 Parameter DIV_CYCLES, default 34, SHALL be the EX-stage occupancy in cycles of a DIV/DIVU/REM/REMU instruction, legal range 2..63.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-006 id_rs1_used, id_rs2_used  input  1 each  the ID instruction actually reads rs1 / rs2.
REQ-007 ex_rd  input  5  destination register index of the instruction in EX.
REQ-008 ex_mem_read  input  1  the EX instruction is a load.
REQ-009 ex_branch_taken  input  1  the EX instruction redirects the PC (taken branch or jump).
REQ-010 ex_md_valid  input  1  the EX instruction is an M-extension operation.
REQ-011 ex_md_is_div  input  1  the M-extension operation is a divide or remainder; qualified by ex_md_valid.
REQ-012 pc_stall  output  1  hold the PC.
REQ-013 if_id_stall  output  1  hold the IF/ID register.
REQ-014 if_id_flush  output  1  load a NOP into IF/ID.
REQ-015 id_ex_stall  output  1  hold the ID/EX register.
REQ-016 id_ex_flush  output  1  load a bubble into ID/EX.
REQ-017 ex_mem_flush  output  1  load a bubble into EX/MEM.
REQ-018 md_busy  output  1  a multi-cycle M operation is occupying EX.
REQ-019 md_done  output  1  one-cycle pulse in the final EX cycle of an M operation.
REQ-020 stall_cycles  output  32  performance counter of cycles with pc_stall=1.

Function
REQ-021 The FSM SHALL have two states: RUN and MD_WAIT, plus a 6-bit down-counter md_cnt.
REQ-022 A load-use hazard SHALL be detected, combinationally, when ex_mem_read=1, ex_rd!=0, and (id_rs1_used=1 and id_rs1=ex_rd) or (id_rs2_used=1 and id_rs2=ex_rd).
REQ-023 In RUN with ex_branch_taken=1: if_id_flush=1 and id_ex_flush=1 in the same cycle; all stall outputs 0; the FSM SHALL stay in RUN.
REQ-024 In RUN with ex_branch_taken=0 and a load-use hazard: pc_stall=1, if_id_stall=1, id_ex_flush=1 for that cycle only.
REQ-025 When ex_branch_taken=1 and a load-use hazard coincide, branch handling (REQ-023) SHALL win and no stall SHALL be asserted.
REQ-026 In RUN with ex_md_valid=1 and ex_branch_taken=0, the block SHALL:
- assert pc_stall, if_id_stall, id_ex_stall, ex_mem_flush and md_busy in that cycle;
- move to MD_WAIT;
- load md_cnt with (ex_md_is_div ? DIV_CYCLES : MUL_CYCLES) - 2.
REQ-027 In MD_WAIT with md_cnt!=0, the block SHALL:
- assert pc_stall, if_id_stall, id_ex_stall, ex_mem_flush and md_busy;
- decrement md_cnt.
REQ-028 In MD_WAIT with md_cnt=0, the block SHALL:
- deassert all stall/flush outputs;
- assert md_busy=1 and md_done=1;
- return to RUN next cycle.
REQ-029 Net effect: an M instruction SHALL occupy EX for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES) and produce exactly N-1 stall cycles.
REQ-030 In MD_WAIT, the load-use, ex_branch_taken and ex_md_valid inputs SHALL be ignored; the still-valid ex_md_valid SHALL NOT retrigger.
REQ-031 An M instruction arriving in EX the cycle after md_done SHALL start a new sequence per REQ-026 with no idle cycle.
REQ-032 ex_md_valid=1 coinciding with a load-use hazard SHALL follow REQ-026 only; the hazard is covered by the ID hold.
REQ-033 stall_cycles SHALL increment by 1 on each clock edge where pc_stall=1, wrapping from 0xFFFFFFFF to 0.
REQ-034 md_done SHALL be 0 in every cycle except the one defined in REQ-028.

Reset
REQ-035 On a rising edge with rst=0, the block SHALL set state=RUN, md_cnt=0 and stall_cycles=0.
REQ-036 While state=RUN after reset, md_busy and md_done SHALL be 0.
REQ-037 Reset asserted during MD_WAIT SHALL abort the sequence with no md_done pulse.
REQ-038 Reset SHALL take priority over every other event on the same edge.

Verification
REQ-039 Load x5 in EX, ID reads rs2=x5 with id_rs2_used=1 -> exactly one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cycles=1.
REQ-040 Load with ex_rd=0, ID reads x0 -> no stall.
REQ-041 MUL in EX (MUL_CYCLES=3) -> stall outputs high for 2 cycles, md_done high in the 3rd cycle, state back in RUN in the 4th cycle; stall_cycles=2.
REQ-042 DIV in EX (DIV_CYCLES=34) -> 33 stall cycles, then one md_done pulse.
REQ-043 DIV followed back-to-back by MUL -> 33 + 2 stall cycles, two md_done pulses, no gap between the sequences.
REQ-044 ex_branch_taken=1 with a concurrent load-use hazard -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
REQ-045 rst=0 asserted in the 10th cycle of a DIV -> RUN next cycle, md_busy=0, no md_done, stall_cycles=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and multi-cycle
// M-extension occupancy of EX, plus a stall-cycle performance counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        ex_md_valid,
    input  logic        ex_md_is_div,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    typedef enum logic [0:0] {StRun, StMdWait} state_e;

    // The first EX cycle is spent in StRun and the last on md_cnt == 0, hence N - 2.
    localparam logic [5:0] MulLoad = 6'(MUL_CYCLES - 32'd2);
    localparam logic [5:0] DivLoad = 6'(DIV_CYCLES - 32'd2);

    state_e      state_q;
    logic [5:0]  md_cnt_q;
    logic [31:0] stall_cycles_q;
    logic        load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StRun;
            md_cnt_q       <= 6'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            if (pc_stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            case (state_q)
                StRun: begin
                    if (ex_md_valid && !ex_branch_taken) begin
                        state_q  <= StMdWait;
                        md_cnt_q <= ex_md_is_div ? DivLoad : MulLoad;
                    end
                end
                StMdWait: begin
                    if (md_cnt_q != 6'd0) begin
                        md_cnt_q <= md_cnt_q - 6'd1;
                    end else begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        case (state_q)
            StRun: begin
                // Branch beats M start, which beats load-use (ID hold covers it).
                if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (ex_md_valid) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    md_busy      = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            StMdWait: begin
                md_busy = 1'b1;
                if (md_cnt_q != 6'd0) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else begin
                    md_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign stall_cycles = stall_cycles_q;

endmodule
